// File: rtl/filter_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : filter_3x3
//  Brief    : Two-stage pipelined 3x3 multiply-accumulate kernel. Stage 1
//             registers the nine element-wise pixel*weight products, stage 2
//             registers their sum. One window per clock, 2-edge latency.
//  Options  : FILTER3X3_SIGNED_EN - treat pixels/weights as two's complement
//             and sign-extend the result; otherwise everything is unsigned.
//  Revision : 1.0 - initial release
// ============================================================================
module filter_3x3 #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 24
) (
  input  logic                clk,
  input  logic                rst,          // asynchronous, active-low
  input  logic [3*DATA_W-1:0] inLine1,
  input  logic [3*DATA_W-1:0] inLine2,
  input  logic [3*DATA_W-1:0] inLine3,
  input  logic [3*DATA_W-1:0] filterLine1,
  input  logic [3*DATA_W-1:0] filterLine2,
  input  logic [3*DATA_W-1:0] filterLine3,
  output logic [OUT_W-1:0]    out
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = OUT_W - PROD_W;

  // Rows concatenated top to bottom; element k = r*3+c sits at slot (8-k),
  // so column 0 of each row is the most significant byte of that row.
  logic [9*DATA_W-1:0] w_pix_all;
  logic [9*DATA_W-1:0] w_wgt_all;
  logic [DATA_W-1:0]   w_pix [9];
  logic [DATA_W-1:0]   w_wgt [9];

  assign w_pix_all = {inLine1, inLine2, inLine3};
  assign w_wgt_all = {filterLine1, filterLine2, filterLine3};

  for (genvar k = 0; k < 9; k++) begin : g_unpack
    assign w_pix[k] = w_pix_all[(8-k)*DATA_W +: DATA_W];
    assign w_wgt[k] = w_wgt_all[(8-k)*DATA_W +: DATA_W];
  end

  logic [PROD_W-1:0] prod_d [9];
  logic [PROD_W-1:0] prod_q [9];
  logic [OUT_W-1:0]  sum_d;
  logic [OUT_W-1:0]  out_q;

  // Stage 1 combinational: element-wise products (no kernel flip).
  always_comb begin
    for (int k = 0; k < 9; k++) begin
`ifdef FILTER3X3_SIGNED_EN
      prod_d[k] = $unsigned($signed(w_pix[k]) * $signed(w_wgt[k]));
`else
      prod_d[k] = w_pix[k] * w_wgt[k];
`endif
    end
  end

  // Stage 1 register: capture the products; reset discards in-flight data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
    end else begin
      for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
    end
  end

  // Adder tree between the stages; products are extended to OUT_W first.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
`ifdef FILTER3X3_SIGNED_EN
      sum_d = sum_d + {{EXT_W{prod_q[k][PROD_W-1]}}, prod_q[k]};
`else
      sum_d = sum_d + {{EXT_W{1'b0}}, prod_q[k]};
`endif
    end
  end

  // Stage 2 register: the visible result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_q <= '0;
    else      out_q <= sum_d;
  end

  assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_filter_3x3
//  Brief    : Directed self-checking bench for filter_3x3 (2-edge latency,
//             async active-low reset, element pairing, throughput 1).
//             Expected values follow FILTER3X3_SIGNED_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_filter_3x3;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 24;

  logic              clk;
  logic              rst;
  logic [23:0]       inLine1, inLine2, inLine3;
  logic [23:0]       filterLine1, filterLine2, filterLine3;
  logic [OUT_W-1:0]  out;

  int checks   = 0;
  int failures = 0;

  filter_3x3 #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .inLine1     (inLine1),
    .inLine2     (inLine2),
    .inLine3     (inLine3),
    .filterLine1 (filterLine1),
    .filterLine2 (filterLine2),
    .filterLine3 (filterLine3),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input logic [23:0] a1, a2, a3, f1, f2, f3);
    inLine1 = a1; inLine2 = a2; inLine3 = a3;
    filterLine1 = f1; filterLine2 = f2; filterLine3 = f3;
  endtask

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs,
                     input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%06h expected=0x%06h", tag, obs, exp);
    end
  endtask

  // Directed windows
  localparam logic [23:0] D1 = {8'd0, 8'd1, 8'd2};
  localparam logic [23:0] D2 = {8'd1, 8'd1, 8'd2};
  localparam logic [23:0] D3 = {8'd2, 8'd0, 8'd2};
  localparam logic [23:0] ONES = {8'd1, 8'd1, 8'd1};
  localparam logic [23:0] W121 = {8'd1, 8'd2, 8'd1};
  localparam logic [23:0] FF3  = 24'hFFFFFF;
  localparam logic [23:0] PIX7 = {8'd7, 8'd0, 8'd0};
  localparam logic [23:0] WT3_C0 = {8'd3, 8'd0, 8'd0};
  localparam logic [23:0] WT3_C2 = {8'd0, 8'd0, 8'd3};

`ifdef FILTER3X3_SIGNED_EN
  localparam logic [OUT_W-1:0] EXP_MAX = 24'd9;          // (-1)*(-1)*9
`else
  localparam logic [OUT_W-1:0] EXP_MAX = 24'd585225;     // 0x08EE09
`endif

  initial begin
    // Reset held with X and then random inputs while the clock runs.
    rst = 1'b0;
    set_win('x, 'x, 'x, 'x, 'x, 'x);
    #1;
    chk("reset_init", out, 24'd0);
    tick();
    chk("reset_x_in", out, 24'd0);
    for (int i = 0; i < 3; i++) begin
      set_win($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      tick();
      chk("reset_hold", out, 24'd0);
    end

    // Release and stream windows back to back.
    rst = 1'b1;
    set_win(D1, D2, D3, ONES, ONES, ONES);           // basic sum -> 11
    tick();
    chk("post_rst_edge1", out, 24'd0);
    set_win(D1, D2, D3, W121, W121, W121);           // weighted -> 13
    tick();
    chk("basic_sum", out, 24'd11);
    set_win(FF3, FF3, FF3, FF3, FF3, FF3);           // max
    tick();
    chk("weighted_b2b", out, 24'd13);
    set_win(24'd0, 24'd0, PIX7, 24'd0, 24'd0, WT3_C0); // pairing hit -> 21
    tick();
    chk("max_value", out, EXP_MAX);
    chk("max_upper_bits", {20'd0, out[23:20]}, 24'd0);
    set_win(24'd0, 24'd0, PIX7, WT3_C2, 24'd0, 24'd0); // pairing miss -> 0
    tick();
    chk("pair_r3c0", out, 24'd21);
    set_win(D1, D2, D3, ONES, ONES, ONES);
    tick();
    chk("pair_mismatch", out, 24'd0);
    tick();
    chk("basic_again", out, 24'd11);

`ifdef FILTER3X3_SIGNED_EN
    set_win(FF3, FF3, FF3, {3{8'd2}}, {3{8'd2}}, {3{8'd2}}); // -18
    tick();
    set_win({3{8'h80}}, {3{8'h80}}, {3{8'h80}},
            {3{8'h80}}, {3{8'h80}}, {3{8'h80}});             // +147456
    tick();
    chk("signed_neg", out, 24'hFFFFEE);
    tick();
    chk("signed_max", out, 24'h024000);
`endif

    // Asynchronous reset mid-cycle: out must drop without an edge.
    set_win(D1, D2, D3, W121, W121, W121);
    tick();
    tick();
    chk("pre_async", out, 24'd13);
    #2;
    rst = 1'b0;
    #1;
    chk("async_drop", out, 24'd0);

    // Reset mid-stream: A and B lost, C emerges 2 edges after release.
    @(negedge clk);
    rst = 1'b1;
    set_win(D1, D2, D3, ONES, ONES, ONES);           // A
    tick();
    set_win(D1, D2, D3, W121, W121, W121);           // B
    tick();
    chk("stream_A", out, 24'd11);
    #2;
    rst = 1'b0;
    #1;
    chk("stream_rst", out, 24'd0);
    set_win(24'd0, 24'd0, PIX7, 24'd0, 24'd0, WT3_C0); // C
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("stream_C_edge1", out, 24'd0);
    set_win(24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
    tick();
    chk("stream_C_edge2", out, 24'd21);
    tick();
    chk("stream_zero", out, 24'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/filter_3x3.md
Name: filter_3x3

Overview:
- Pipelined 3x3 convolution kernel (multiply-accumulate) for the conv datapath.
- Each cycle it takes one 3x3 window of 8-bit pixels and one 3x3 set of 8-bit weights.
- It multiplies the nine pixel/weight pairs element-wise and sums the products.
- The 24-bit result appears after a fixed 2-cycle latency; fully pipelined, one window accepted per clock.

Parameters:
- DATA_W, 8: width of one pixel and of one weight element.
- OUT_W, 24: width of the result; must be at least 2*DATA_W+4. Zero/sign-extended to OUT_W.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- inLine1  input  3*DATA_W  window row 1: [23:16]=col0, [15:8]=col1, [7:0]=col2.
- inLine2  input  3*DATA_W  window row 2, same packing.
- inLine3  input  3*DATA_W  window row 3, same packing.
- filterLine1  input  3*DATA_W  weight row 1, same packing.
- filterLine2  input  3*DATA_W  weight row 2.
- filterLine3  input  3*DATA_W  weight row 3.
- out  output  OUT_W  registered convolution result.

Behaviour:
- Default arithmetic is unsigned:
  - out = sum over r,c of in[r][c]*filter[r][c].
  - Element (r,c) of an input pairs only with element (r,c) of the filter. No kernel flip.
- Stage 1, rising edge: register the nine 2*DATA_W-bit products p[r][c] from the current inputs.
- Stage 2, rising edge: sum the nine registered products into OUT_W bits and register the sum as out.
  - Adder tree is combinational between the stages.
- Latency: inputs present before rising edge N appear on out after rising edge N+1 (2 edges). Throughput: 1 window per cycle.
- Width: maximum unsigned result 9*255*255 = 585225, fits in 20 bits. Upper bits of out are zero. No overflow or saturation logic needed.
- No handshake: every cycle's inputs are sampled unconditionally. Upstream holds or changes inputs freely.
- Reset, rst=0, asynchronous:
  - All product registers and out are cleared to 0 immediately, independent of clk.
- Reset mid-operation: in-flight windows are discarded.
- After rst is released:
  - out stays 0 for the first edge.
  - The window sampled at the first post-reset edge appears after the second edge.
- X-free: out must never be X after reset, even if inputs were X during reset.
- Inputs change only away from the rising edge; no combinational path from inputs to out.

Optional Feature:
- Macro FILTER3X3_SIGNED_EN.
- When defined:
  - Pixels and weights are two's-complement DATA_W-bit values.
  - Products are signed 2*DATA_W bits.
  - The sum is sign-extended to OUT_W.
  - Range is -9*128*127 to 9*128*128, i.e. -146304..147456.
- When undefined: unsigned behaviour as above.
- Latency, reset and port list are identical in both builds.

Test Plan:
- Reset: hold rst=0 with random inputs and toggling clk -> out=0 throughout. Assert rst=0 asynchronously mid-cycle -> out drops to 0 without waiting for an edge.
- Basic sum: rows {0,1,2},{1,1,2},{2,0,2}, all weights 1 -> out=11 two edges later.
- Weighted: same data, every filter row {1,2,1} -> out=13. Apply back-to-back after the previous case: out shows 11 then 13 on consecutive cycles (throughput 1).
- Max unsigned: all pixels 255, all weights 255 -> out=585225 (0x08EE09). Upper bits zero.
- Position pairing: single nonzero pixel 7 at row3 col0 ([23:16] of inLine3), filter weight 3 only there -> out=21. Move the weight to row1 col2 -> out=0.
- Reset mid-stream: apply windows A, B, C and assert rst between B and C -> A/B results lost, out=0. After release, C's result appears exactly 2 edges after its first sampling edge.
- Signed build (FILTER3X3_SIGNED_EN): all pixels -1 (0xFF), all weights 2 -> out=-18 (0xFFFFEE).
